approx_adder_error_monitor: RTL and testbench
=============================================

// Module: approx_adder_error_monitor
// PURPOSE
// Consumer end of the approximate ripple-carry adder interface: takes {IN1, IN2, Out} sample triples from an adder under
// test, recomputes the exact sum and accumulates error metrics over a window of 2**SAMPLES_LOG2 samples.
// Reports sum of absolute error, MAE, worst-case error and the operands that produced it, and error count.
// Sits beside the RC_* adders in characterization benches and on-chip self-test harnesses.
// PARAMETERS
// WIDTH        8  operand width; approx sum input is WIDTH+1 bits
// SAMPLES_LOG2 8  window = 2**SAMPLES_LOG2 accepted samples
// PORTS
// clk         in   1                     rising-edge clock
// rst         in   1                     synchronous, active-high reset
// start       in   1                     begin new window (sampled in IDLE/DONE only)
// in_valid    in   1                     sample triple valid
// in_ready    out  1                     monitor accepts sample this cycle
// in_a        in   WIDTH                 adder IN1
// in_b        in   WIDTH                 adder IN2
// in_approx   in   WIDTH+1               adder Out (approximate sum)
// busy        out  1                     high in RUN and DRAIN
// done        out  1                     one-cycle pulse when results valid
// sum_abs_err out  WIDTH+1+SAMPLES_LOG2  sum of |exact-approx| over window
// mae         out  WIDTH+1               sum_abs_err >> SAMPLES_LOG2 (truncating)
// max_abs_err out  WIDTH+1               largest |exact-approx| in window
// wce_a       out  WIDTH                 in_a of first sample reaching max_abs_err
// wce_b       out  WIDTH                 in_b of same sample
// err_count   out  SAMPLES_LOG2+1        samples with nonzero error
// BEHAVIOUR
// - Reset: FSM=IDLE; in_ready, busy, done=0; all result outputs and counters=0; pipeline valids cleared.
// - FSM IDLE -> RUN on start. RUN -> DRAIN when accepted count reaches 2**SAMPLES_LOG2.
//   DRAIN -> DONE when pipeline empty. DONE -> RUN on start, else stays DONE.
// - Entering RUN: clear accumulators, max, wce, err_count and sample counter in that same cycle.
// - Handshake: in_ready = (state==RUN) && (count < 2**SAMPLES_LOG2). Transfer when in_valid&&in_ready.
//   Inputs ignored otherwise. in_ready is registered-state-derived, with no combinational path from in_valid.
// - Pipeline stage 1, registered: exact = in_a+in_b (WIDTH+1 bits, zero-extended).
//   abs_err = exact>=in_approx ? exact-in_approx : in_approx-exact (WIDTH+1 bits, unsigned).
//   Operands are carried along.
// - Stage 2, registered: sum_abs_err += abs_err (cannot overflow at chosen width);
//   err_count += (abs_err!=0); if abs_err > max_abs_err, update max_abs_err, wce_a and wce_b.
//   Ties keep the earlier sample.
// - Latency: a sample accepted in cycle t is reflected in the accumulators at end of cycle t+2.
// - done asserts exactly one cycle, on the DRAIN->DONE transition. Results hold until next start.
//   mae is combinational from sum_abs_err.
// - start while in RUN/DRAIN is ignored. Back-to-back transfers run at one per cycle with no bubbles.
// - rst mid-window discards all partial results immediately and returns to IDLE; done is not pulsed.
// TESTING (use SAMPLES_LOG2=2 unless noted)
// 1 Exact adder: 4 samples (3,5,8),(255,255,510),(0,0,0),(128,1,129).
//   Expect sum=0, mae=0, max=0, err_count=0, done after 4th accept+2 cycles.
// 2 Errors: (3,5,6),(10,10,25),(0,1,0),(7,7,14).
//   Expect abs 2,5,1,0: sum=8, mae=2, max=5, wce_a=10, wce_b=10, err_count=3.
// 3 Tie/stall: errors 4,4 on samples 1 and 3, with in_valid gapped by 3 idle cycles.
//   Expect wce from sample 1; in_ready stays 1 until 4 accepts, then 0.
// 4 Extreme: WIDTH=8, SAMPLES_LOG2=8, all samples (255,255,0).
//   Expect max=510, sum=130560, mae=510, err_count=256 (no overflow).
// 5 Control: start during RUN has no effect. rst after 2 accepts -> outputs 0, IDLE, no done.
//   New start then gives a clean window.
// 6 Restart from DONE: start clears results the same cycle; in_ready=1 next cycle; second window is independent of the first.

Source files
------------

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - error-metric accumulator for an approximate adder under test
// Two-stage pipeline: stage 1 forms |exact-approx|, stage 2 folds it into the window statistics.
module approx_adder_error_monitor #(
    parameter int WIDTH        = 8,
    parameter int SAMPLES_LOG2 = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_a,
    input  logic [WIDTH-1:0]                in_b,
    input  logic [WIDTH:0]                  in_approx,
    output logic                            busy,
    output logic                            done,
    output logic [WIDTH+SAMPLES_LOG2:0]     sum_abs_err,
    output logic [WIDTH:0]                  mae,
    output logic [WIDTH:0]                  max_abs_err,
    output logic [WIDTH-1:0]                wce_a,
    output logic [WIDTH-1:0]                wce_b,
    output logic [SAMPLES_LOG2:0]           err_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [SAMPLES_LOG2:0] WINDOW = {1'b1, {SAMPLES_LOG2{1'b0}}};
    localparam logic [SAMPLES_LOG2:0] LAST   = WINDOW - {{SAMPLES_LOG2{1'b0}}, 1'b1};

    logic [1:0]                    r_state;
    logic [SAMPLES_LOG2:0]         r_count;
    logic                          r_done;
    logic                          r_s1_valid;
    logic [WIDTH:0]                r_s1_abs;
    logic [WIDTH-1:0]              r_s1_a;
    logic [WIDTH-1:0]              r_s1_b;
    logic [WIDTH+SAMPLES_LOG2:0]   r_sum;
    logic [WIDTH:0]                r_max;
    logic [WIDTH-1:0]              r_wce_a;
    logic [WIDTH-1:0]              r_wce_b;
    logic [SAMPLES_LOG2:0]         r_err_count;

    logic                          w_ready;
    logic                          w_xfer;
    logic [WIDTH:0]                w_exact;
    logic [WIDTH:0]                w_abs;

    assign w_ready = (r_state == ST_RUN) && (r_count < WINDOW);
    assign w_xfer  = in_valid && w_ready;
    assign w_exact = {1'b0, in_a} + {1'b0, in_b};
    assign w_abs   = (w_exact >= in_approx) ? (w_exact - in_approx) : (in_approx - w_exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_abs    <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_sum       <= '0;
            r_max       <= '0;
            r_wce_a     <= '0;
            r_wce_b     <= '0;
            r_err_count <= '0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_abs <= w_abs;
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
            end

            // Strict compare so a tie keeps the earlier sample's operands.
            if (r_s1_valid) begin
                r_sum       <= r_sum + {{SAMPLES_LOG2{1'b0}}, r_s1_abs};
                r_err_count <= r_err_count + {{SAMPLES_LOG2{1'b0}}, (r_s1_abs != '0)};
                if (r_s1_abs > r_max) begin
                    r_max   <= r_s1_abs;
                    r_wce_a <= r_s1_a;
                    r_wce_b <= r_s1_b;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_count     <= '0;
                        r_sum       <= '0;
                        r_max       <= '0;
                        r_wce_a     <= '0;
                        r_wce_b     <= '0;
                        r_err_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        r_count <= r_count + {{SAMPLES_LOG2{1'b0}}, 1'b1};
                        if (r_count == LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // No transfers are taken here, so stage 1 retires its last sample on this edge.
                    if (!w_xfer) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done        = r_done;
    assign sum_abs_err = r_sum;
    assign mae         = r_sum[WIDTH+SAMPLES_LOG2:SAMPLES_LOG2];
    assign max_abs_err = r_max;
    assign wce_a       = r_wce_a;
    assign wce_b       = r_wce_b;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb/tb_approx_adder_error_monitor.sv - randomized self-checking bench for approx_adder_error_monitor
// Expected statistics come from integer arithmetic over the samples the bench itself sent.
module tb_approx_adder_error_monitor;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int NS = 1 << S;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic [W:0]         in_approx;
    logic               busy;
    logic               done;
    logic [W+S:0]       sum_abs_err;
    logic [W:0]         mae;
    logic [W:0]         max_abs_err;
    logic [W-1:0]       wce_a;
    logic [W-1:0]       wce_b;
    logic [S:0]         err_count;

    int checks = 0;
    int errors = 0;

    int m_a  [NS];
    int m_b  [NS];
    int m_ap [NS];

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.WIDTH(W), .SAMPLES_LOG2(S)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .busy(busy), .done(done),
        .sum_abs_err(sum_abs_err), .mae(mae), .max_abs_err(max_abs_err),
        .wce_a(wce_a), .wce_b(wce_b), .err_count(err_count)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int ap);
        int t;
        in_a      = a[W-1:0];
        in_b      = b[W-1:0];
        in_approx = ap[W:0];
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_results(input string tag);
        longint e, esum, emax, ecnt, ea, eb;
        esum = 0; emax = 0; ecnt = 0; ea = 0; eb = 0;
        for (int i = 0; i < NS; i++) begin
            e = longint'(m_a[i] + m_b[i]) - longint'(m_ap[i]);
            if (e < 0) e = -e;
            esum += e;
            if (e != 0) ecnt++;
            if (e > emax) begin
                emax = e; ea = m_a[i]; eb = m_b[i];
            end
        end
        check({tag, "_sum"},   sum_abs_err, esum);
        check({tag, "_mae"},   mae,         esum / NS);
        check({tag, "_max"},   max_abs_err, emax);
        check({tag, "_wce_a"}, wce_a,       ea);
        check({tag, "_wce_b"}, wce_b,       eb);
        check({tag, "_errs"},  err_count,   ecnt);
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each sample
    task automatic run_window(input string tag, input int gap);
        int g, c;
        for (int i = 0; i < NS; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                check({tag, "_gap_ready"}, in_ready, 1);
            end
            send(m_a[i], m_b[i], m_ap[i]);
        end
        check({tag, "_ready_after_full"}, in_ready, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 20);
        check({tag, "_done_latency"}, c, 2);
        check_results(tag);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check_results({tag, "_hold"});
    endtask

    task automatic load(input int idx, input int a, input int b, input int ap);
        m_a[idx] = a; m_b[idx] = b; m_ap[idx] = ap;
    endtask

    task automatic load_random();
        int ex;
        for (int i = 0; i < NS; i++) begin
            m_a[i] = int'($urandom_range(0, 255));
            m_b[i] = int'($urandom_range(0, 255));
            ex = m_a[i] + m_b[i];
            case ($urandom_range(0, 3))
                0:       m_ap[i] = ex;
                1:       m_ap[i] = (ex ^ int'($urandom_range(0, 7))) & 511;
                default: m_ap[i] = int'($urandom_range(0, 511));
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_sum",   sum_abs_err, 0);
        check("rst_max",   max_abs_err, 0);
        check("rst_errs",  err_count, 0);

        pulse_start();
        check("start_ready", in_ready, 1);
        check("start_busy",  busy, 1);
        load(0, 3, 5, 8); load(1, 255, 255, 510); load(2, 0, 0, 0); load(3, 128, 1, 129);
        run_window("exact", 0);
        check("exact_sum_const", sum_abs_err, 0);

        pulse_start();
        load(0, 3, 5, 6); load(1, 10, 10, 25); load(2, 0, 1, 0); load(3, 7, 7, 14);
        run_window("errs", 0);
        check("errs_sum_const",  sum_abs_err, 8);
        check("errs_wce_const",  wce_a, 10);

        pulse_start();
        load(0, 1, 2, 7); load(1, 5, 5, 10); load(2, 9, 9, 14); load(3, 0, 0, 0);
        run_window("tie", 3);
        check("tie_wce_a_const", wce_a, 1);

        pulse_start();
        for (int i = 0; i < NS; i++) load(i, 255, 255, 0);
        run_window("extreme", 0);
        check("extreme_max_const", max_abs_err, 510);

        // Restart from DONE clears results on the start edge.
        pulse_start();
        check("restart_sum",   sum_abs_err, 0);
        check("restart_max",   max_abs_err, 0);
        check("restart_errs",  err_count, 0);
        check("restart_ready", in_ready, 1);

        load(0, 4, 4, 0); load(1, 20, 30, 0);
        send(4, 4, 0);
        send(20, 30, 0);
        pulse_start();
        check("run_start_busy",  busy, 1);
        check("run_start_ready", in_ready, 1);
        @(negedge clk);
        check("run_start_keeps_sum", sum_abs_err, 58);
        pulse_reset();
        check("midrst_busy",  busy, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_sum",   sum_abs_err, 0);
        check("midrst_max",   max_abs_err, 0);
        check("midrst_errs",  err_count, 0);
        check("midrst_wce_a", wce_a, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end

        for (int w = 0; w < 10; w++) begin
            pulse_start();
            load_random();
            run_window("rand", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
